ks_adder_pipe: RTL and testbench

//  Parametrised, pipelined Kogge-Stone add/subtract unit with valid/ready flow control.
//  It is the next-generation arithmetic core of the circuits library, following the fixed 32b KSA.

---
 rtl/ks_adder_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_ks_adder_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with valid/ready flow control,
// configurable register cuts in the prefix tree and a lower-part-OR approximate mode.
module ks_adder_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int APPROX_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int LV = $clog2(WIDTH);
  localparam int PS = PIPE_STAGES;
  localparam int K  = APPROX_BITS;

  // Cut c sits at the level boundary ceil(c*LV/(PS+1)), spreading cuts evenly over the tree.
  function automatic int cut_pos(input int c);
    return (c * LV + PS) / (PS + 1);
  endfunction

  function automatic int cut_at(input int l);
    for (int c = 1; c <= PS; c++) begin
      if (cut_pos(c) == l) return c;
    end
    return 0;
  endfunction

  // ---------------------------------------------------------------- operand prep
  logic [WIDTH-1:0] ye, h_in, g_in, pf;
  logic             c0_in, lo_mode;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    ye      = sub ? ~y : y;
    lo_mode = approx_en && (K > 0);
    c0_in   = cin ^ sub;
    h_in    = x ^ ye;
    pf      = x ^ ye;
    g_in    = x & ye;
    if (lo_mode) begin
      // Low bits become OR cells; only bit K-1 generates the carry into the exact part.
      c0_in = 1'b0;
      for (int i = 0; i < K; i++) begin
        h_in[i] = x[i] | ye[i];
        pf[i]   = 1'b0;
        if (i != K - 1) g_in[i] = 1'b0;
      end
    end
    g_in[0] = g_in[0] | (pf[0] & c0_in);
  end

  // ---------------------------------------------------------------- stage registers
  logic [PS:0]      st_v, st_c0, st_xm;
  logic [WIDTH-1:0] st_h [0:PS];
  logic [WIDTH-1:0] g0_q;
  logic [WIDTH-1:1] p0_q;
  logic [PS:0]      adv;
  logic             adv_out, full;

  // Stage k may load when it is empty or every stage below it down to the output can move.
  always_comb begin
    adv_out = ~out_valid | out_ready;
    full    = 1'b1;
    adv     = '0;
    for (int k = PS; k >= 0; k--) begin
      full   = full & st_v[k];
      adv[k] = adv_out | ~full;
    end
  end

  assign in_ready = rst & adv[0];

  // NOTE: sequential state is written with non-blocking assignments only, so stage k
  // captures the value stage k-1 held before this edge.
  // NOTE: data registers are cleared on reset too, so s/ovf read 0 right after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_v  <= '0;
      st_c0 <= '0;
      st_xm <= '0;
      g0_q  <= '0;
      p0_q  <= '0;
      for (int k = 0; k <= PS; k++) st_h[k] <= '0;
    end else begin
      if (adv[0]) begin
        st_v[0] <= in_valid;
        if (in_valid) begin
          g0_q     <= g_in;
          p0_q     <= pf[WIDTH-1:1];
          st_h[0]  <= h_in;
          st_c0[0] <= c0_in;
          st_xm[0] <= x[WIDTH-1];
        end
      end
      for (int k = 1; k <= PS; k++) begin
        if (adv[k]) begin
          st_v[k] <= st_v[k-1];
          if (st_v[k-1]) begin
            st_h[k]  <= st_h[k-1];
            st_c0[k] <= st_c0[k-1];
            st_xm[k] <= st_xm[k-1];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- prefix tree
  // Boundary l carries group G for every bit and group P only for bits >= 2^l,
  // the only ones the remaining levels still consume.
  for (genvar l = 0; l <= LV; l++) begin : bnd
    localparam int C = cut_at(l);
    logic [WIDTH-1:0] g;
    if (l == 0) begin : g_from_in
      assign g = g0_q;
    end else if (C != 0) begin : g_from_cut
      assign g = cut[C].g_q;
    end else begin : g_from_lvl
      assign g = lvl[l-1].g_o;
    end
    if (l < LV) begin : has_p
      logic [WIDTH-1:(1<<l)] p;
      if (l == 0) begin : p_from_in
        assign p = p0_q;
      end else if (C != 0) begin : p_from_cut
        assign p = cut[C].has_p.p_q;
      end else begin : p_from_lvl
        assign p = lvl[l-1].has_p.p_o;
      end
    end
  end

  for (genvar l = 0; l < LV; l++) begin : lvl
    localparam int SPAN = 1 << l;
    logic [WIDTH-1:0] g_o;
    always_comb begin
      g_o = bnd[l].g;
      for (int i = SPAN; i < WIDTH; i++)
        g_o[i] = bnd[l].g[i] | (bnd[l].has_p.p[i] & bnd[l].g[i-SPAN]);
    end
    if (2 * SPAN < WIDTH) begin : has_p
      logic [WIDTH-1:2*SPAN] p_o;
      always_comb begin
        p_o = '0;
        for (int i = 2 * SPAN; i < WIDTH; i++)
          p_o[i] = bnd[l].has_p.p[i] & bnd[l].has_p.p[i-SPAN];
      end
    end
  end

  for (genvar c = 1; c <= PS; c++) begin : cut
    localparam int POS = cut_pos(c);
    logic [WIDTH-1:0] g_q;
    always_ff @(posedge clk) begin
      if (!rst)                        g_q <= '0;
      else if (adv[c] && st_v[c-1])    g_q <= lvl[POS-1].g_o;
    end
    if (POS < LV) begin : has_p
      logic [WIDTH-1:(1<<POS)] p_q;
      always_ff @(posedge clk) begin
        if (!rst)                      p_q <= '0;
        else if (adv[c] && st_v[c-1])  p_q <= lvl[POS-1].has_p.p_o;
      end
    end
  end

  // ---------------------------------------------------------------- sum and output
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;
  logic             ovf_w;

  assign carry = {bnd[LV].g, st_c0[PS]};
  assign sum_w = st_h[PS] ^ carry[WIDTH-1:0];
  // Operand MSBs agree exactly when the MSB half-sum is 0 (the MSB is never approximated).
  assign ovf_w = ~st_h[PS][WIDTH-1] & (sum_w[WIDTH-1] ^ st_xm[PS]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      ovf       <= 1'b0;
    end else if (adv_out) begin
      out_valid <= st_v[PS];
      if (st_v[PS]) begin
        s   <= {carry[WIDTH], sum_w};
        ovf <= ovf_w;
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe: directed corner vectors, backpressure,
// a long randomized handshake run against an arithmetic reference model, and mid-operation reset.
module tb_ks_adder_pipe;

  localparam int WIDTH       = 32;
  localparam int PIPE_STAGES = 2;
  localparam int APPROX_BITS = 8;
  localparam int L           = PIPE_STAGES + 2;
  localparam int K           = APPROX_BITS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  x = '0;
  logic [WIDTH-1:0]  y = '0;
  logic              cin = 1'b0;
  logic              sub = 1'b0;
  logic              approx_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH:0]    s;
  logic              ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ks_adder_pipe #(
    .WIDTH      (WIDTH),
    .PIPE_STAGES(PIPE_STAGES),
    .APPROX_BITS(APPROX_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .cin      (cin),
    .sub      (sub),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .ovf      (ovf)
  );

  // Reference: plain integer arithmetic on the operands; returns {ovf, s}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic ci, input logic sb, input logic ap);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   ax, bx, hi, mask, sum;
    logic             ov;
    be = sb ? ~b : b;
    ax = {1'b0, a};
    bx = {1'b0, be};
    if (ap) begin
      hi   = (ax >> K) + (bx >> K) + {{WIDTH{1'b0}}, a[K-1] & be[K-1]};
      mask = ({{WIDTH{1'b0}}, 1'b1} << K) - {{WIDTH{1'b0}}, 1'b1};
      sum  = (hi << K) | ((ax | bx) & mask);
    end else begin
      sum = ax + bx + {{WIDTH{1'b0}}, ci ^ sb};
    end
    ov = (a[WIDTH-1] == be[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return {ov, sum};
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    x = 32'h1234_5678;
    y = 32'h0000_0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (s !== 33'h0) begin n_fail++; $display("FAIL reset_s: got %h expected 0", s); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
  endtask

  // One isolated beat: checks acceptance, latency L and the result.
  task automatic test_single_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic ci, input logic sb, input logic ap,
                                  input logic [WIDTH:0] exp_s, input logic exp_ovf, input string name);
    int edges;
    bit seen;
    @(posedge clk); #1;
    x = a; y = b; cin = ci; sub = sb; approx_en = ap;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept: in_ready %b expected 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    n_checks++;
    if (!seen || edges != L) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0b) expected %0d", name, edges, seen, L);
    end
    if (seen) begin
      n_checks++; if (s !== exp_s) begin n_fail++; $display("FAIL %s_s: got %h expected %h", name, s, exp_s); end
      n_checks++; if (ovf !== exp_ovf) begin n_fail++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, exp_ovf); end
    end
  endtask

  task automatic test_directed();
    test_single_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0, "add_wrap");
    test_single_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1, "ovf_pos");
    test_single_beat(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 33'h1_0000_0000, 1'b1, "ovf_neg");
    test_single_beat(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 33'h0_FFFF_FFFE, 1'b0, "sub_neg");
    test_single_beat(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 33'h1_0000_0002, 1'b0, "sub_pos");
    test_single_beat(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 33'h1_0000_0001, 1'b0, "sub_borrow");
    test_single_beat(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 33'h0_0000_00FF, 1'b0, "approx_or");
    test_single_beat(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33'h0_0000_0100, 1'b0, "approx_off");
    test_single_beat(32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 33'h0_0000_0180, 1'b0, "approx_carry");
  endtask

  task automatic test_backpressure();
    int acc, got, stray;
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (acc < 8);
      x         = acc;
      y         = acc;
      cin       = 1'b0;
      sub       = 1'b0;
      approx_en = 1'b0;
      out_ready = (cyc >= 6);
      @(negedge clk);
      if (!out_ready && acc == L) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b expected 0 at cycle %0d", in_ready, cyc); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (s !== 33'(2 * got)) begin n_fail++; $display("FAIL bp_order: beat %0d got %h expected %h", got, s, 33'(2 * got)); end
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d results expected 8", got); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
      @(posedge clk);
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL bp_duplicate: got %0d extra results expected 0", stray); end
  endtask

  task automatic test_random();
    logic [WIDTH+1:0] exp_q [$];
    logic [WIDTH+1:0] got, exp_v, held, prev;
    bit hold_pend, prev_ok;
    int acc, ret;
    acc = 0;
    ret = 0;
    hold_pend = 1'b0;
    prev_ok = 1'b0;
    held = '0;
    prev = '0;
    for (int cyc = 0; cyc < 40000 && !(acc == 10000 && ret == acc); cyc++) begin
      @(posedge clk); #1;
      in_valid  = (acc < 10000) && ($urandom_range(3) != 0);
      x         = pick();
      y         = pick();
      cin       = 1'($urandom_range(1));
      sub       = 1'($urandom_range(1));
      approx_en = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      got = {ovf, s};
      if (hold_pend) begin
        n_checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          n_fail++;
          $display("FAIL rnd_hold: got valid=%b %h expected valid=1 %h", out_valid, got, held);
        end
      end
      if (prev_ok && out_valid !== 1'b1) begin
        n_checks++;
        if (got !== prev) begin n_fail++; $display("FAIL rnd_idle_stable: got %h expected %h", got, prev); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_unexpected: got %h expected no result", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin n_fail++; $display("FAIL rnd_result: beat %0d got %h expected %h", ret, got, exp_v); end
        end
        ret++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x, y, cin, sub, approx_en));
        acc++;
      end
      hold_pend = out_valid && !out_ready;
      held = got;
      prev = got;
      prev_ok = 1'b1;
    end
    n_checks++; if (acc != 10000 || ret != acc) begin n_fail++; $display("FAIL rnd_count: got accepted=%0d retired=%0d expected 10000 each", acc, ret); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d pending expected 0", exp_q.size()); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    int stray;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      x = 32'h100 + i;
      y = 32'h1;
      cin = 1'b0; sub = 1'b0; approx_en = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_fill_%0d: in_ready %b expected 1", i, in_ready); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (s !== 33'h0) begin n_fail++; $display("FAIL mid_s: got %h expected 0", s); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", ovf); end
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL mid_stale: got %0d stale results expected 0", stray); end
    test_single_beat(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 33'h0_2345_6789, 1'b0, "mid_fresh");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
